// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttt_pkg
// Description : Shared cell/who codes, line table, preference lists and FSM
//               state type for the tic-tac-toe move engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] PX    = 2'b01;
    localparam logic [1:0] PO    = 2'b10;
    localparam logic [1:0] BAD   = 2'b11;

    localparam logic [1:0] WHO_PLAY = 2'b00;
    localparam logic [1:0] WHO_XWIN = 2'b01;
    localparam logic [1:0] WHO_OWIN = 2'b10;
    localparam logic [1:0] WHO_DRAW = 2'b11;

    // Rows, columns, then diagonals; the order decides which win/block is kept.
    localparam logic [3:0] LINE_TBL [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] CORNERS [4] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam logic [3:0] EDGES   [4] = '{4'd1, 4'd3, 4'd5, 4'd7};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_PICK  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    function automatic logic [3:0] count_code(input logic [8:0][1:0] b,
                                              input logic [1:0]      code);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            if (b[i] == code) n = n + 4'd1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_line_eval.sv
`default_nettype none
// ============================================================================
// Module      : ttt_line_eval
// Description : Combinational classifier for one three-cell board line.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] cell0_i,
    input  logic [1:0] cell1_i,
    input  logic [1:0] cell2_i,
    input  logic [3:0] idx0_i,
    input  logic [3:0] idx1_i,
    input  logic [3:0] idx2_i,
    output logic       o_two_o,
    output logic       x_two_o,
    output logic [3:0] empty_idx_o
);

    logic [1:0] w_n_o;
    logic [1:0] w_n_x;
    logic [1:0] w_n_e;

    assign w_n_o = 2'(cell0_i == PO)    + 2'(cell1_i == PO)    + 2'(cell2_i == PO);
    assign w_n_x = 2'(cell0_i == PX)    + 2'(cell1_i == PX)    + 2'(cell2_i == PX);
    assign w_n_e = 2'(cell0_i == EMPTY) + 2'(cell1_i == EMPTY) + 2'(cell2_i == EMPTY);

    assign o_two_o = (w_n_o == 2'd2) && (w_n_e == 2'd1);
    assign x_two_o = (w_n_x == 2'd2) && (w_n_e == 2'd1);

    always_comb begin
        empty_idx_o = idx2_i;
        if (cell0_i == EMPTY)      empty_idx_o = idx0_i;
        else if (cell1_i == EMPTY) empty_idx_o = idx1_i;
    end

endmodule
`default_nettype wire

// File: rtl/ttt_move_engine.sv
`default_nettype none
// ============================================================================
// Module      : ttt_move_engine
// Description : Computer opponent: detects its turn, scans a board snapshot,
//               picks a move by fixed priority and requests it from the game.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_move_engine
    import ttt_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] who,
    output logic       pc,
    output logic [3:0] computer_position,
    output logic       busy,
    output logic       error
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [8:0][1:0]   snap_q, snap_d;
    logic [2:0]        line_q, line_d;
    logic              win_vld_q, win_vld_d;
    logic [3:0]        win_idx_q, win_idx_d;
    logic              blk_vld_q, blk_vld_d;
    logic [3:0]        blk_idx_q, blk_idx_d;
    logic [3:0]        pos_q, pos_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              err_q, err_d;

    logic [8:0][1:0]   w_board;
    logic [3:0]        w_nx, w_no, w_ne, w_nbad;
    logic              w_in_play, w_trigger, w_fault;
    logic              w_o_two, w_x_two;
    logic [3:0]        w_empty_idx;
    logic [3:0]        w_pick;
    logic              w_found;

    assign w_board   = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    assign w_nx      = count_code(w_board, PX);
    assign w_no      = count_code(w_board, PO);
    assign w_ne      = count_code(w_board, EMPTY);
    assign w_nbad    = count_code(w_board, BAD);
    assign w_in_play = enable && (who == WHO_PLAY);
    assign w_trigger = w_in_play && (w_nx == w_no + 4'd1) && (w_ne != 4'd0);
    assign w_fault   = (w_nbad != 4'd0) || !((w_nx == w_no) || (w_nx == w_no + 4'd1));

    ttt_line_eval u_line_eval (
        .cell0_i     (snap_q[LINE_TBL[line_q][0]]),
        .cell1_i     (snap_q[LINE_TBL[line_q][1]]),
        .cell2_i     (snap_q[LINE_TBL[line_q][2]]),
        .idx0_i      (LINE_TBL[line_q][0]),
        .idx1_i      (LINE_TBL[line_q][1]),
        .idx2_i      (LINE_TBL[line_q][2]),
        .o_two_o     (w_o_two),
        .x_two_o     (w_x_two),
        .empty_idx_o (w_empty_idx)
    );

    // Snapshot always has an empty cell here, so one of the branches hits.
    always_comb begin
        w_pick  = 4'd0;
        w_found = 1'b0;
        if (win_vld_q) begin
            w_pick = win_idx_q;
        end else if (blk_vld_q) begin
            w_pick = blk_idx_q;
        end else if (snap_q[4] == EMPTY) begin
            w_pick = 4'd4;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!w_found && snap_q[CORNERS[i]] == EMPTY) begin
                    w_pick  = CORNERS[i];
                    w_found = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!w_found && snap_q[EDGES[i]] == EMPTY) begin
                    w_pick  = EDGES[i];
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        line_d    = line_q;
        win_vld_d = win_vld_q;
        win_idx_d = win_idx_q;
        blk_vld_d = blk_vld_q;
        blk_idx_d = blk_idx_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        err_d     = err_q | w_fault;

        case (state_q)
            ST_IDLE: begin
                if (w_trigger) begin
                    snap_d    = w_board;
                    line_d    = 3'd0;
                    win_vld_d = 1'b0;
                    blk_vld_d = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!w_in_play) begin
                    state_d = ST_IDLE;
                end else begin
                    if (w_o_two && !win_vld_q) begin
                        win_vld_d = 1'b1;
                        win_idx_d = w_empty_idx;
                    end
                    if (w_x_two && !blk_vld_q) begin
                        blk_vld_d = 1'b1;
                        blk_idx_d = w_empty_idx;
                    end
                    line_d = line_q + 3'd1;
                    if (line_q == 3'd7) state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                if (!w_in_play) begin
                    state_d = ST_IDLE;
                end else begin
                    pos_d   = w_pick;
                    hold_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!w_in_play) begin
                    state_d = ST_IDLE;
                end else if (w_board[pos_q] == PO) begin
                    state_d = ST_WAIT;
                end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if ((w_nx == w_no) || !w_in_play) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            line_q    <= '0;
            win_vld_q <= 1'b0;
            win_idx_q <= '0;
            blk_vld_q <= 1'b0;
            blk_idx_q <= '0;
            pos_q     <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            line_q    <= line_d;
            win_vld_q <= win_vld_d;
            win_idx_q <= win_idx_d;
            blk_vld_q <= blk_vld_d;
            blk_idx_q <= blk_idx_d;
            pos_q     <= pos_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    assign pc                = (state_q == ST_ISSUE);
    assign busy              = (state_q != ST_IDLE);
    assign computer_position = pos_q;
    assign error             = err_q;

endmodule
`default_nettype wire

// File: doc/ttt_move_engine.md
# ttt_move_engine

- Computer-side opponent for `tic_tac_toe_game`.
- Watches the board outputs `pos1`..`pos9` and `who`, and decides when it is the computer's turn.
- Picks a move with a fixed-priority rule (win, block, centre, corner, edge).
- Drives the game's `pc` and `computer_position` inputs, holding the request until the board shows the computer mark or a timeout expires.

## Interface
- `HOLD_CYCLES`, default 5: maximum cycles `pc` stays high waiting for the board to show the move.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 1 = computer plays; 0 = engine idle (player-vs-player).
- `pos1`..`pos9` in 2 each: board cells. 00 empty, 01 player (X), 10 computer (O), 11 invalid.
- `who` in 2: 00 game in progress, 01 player won, 10 computer won, 11 draw.
- `pc` out 1: computer-move request to the game.
- `computer_position` out 4: chosen cell, 0..8, where cell k = `pos(k+1)`.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky fault flag; cleared only by reset.

## Operation
- Reset values: all outputs 0, state IDLE.
- Counts: nx = number of 01 cells, no = number of 10 cells.
- Trigger: `enable`=1 AND `who`=00 AND nx = no+1 AND at least one empty cell.
- `error` is set if any cell is 11, or nx−no is not 0 or 1; error does not block play.
- States:
  - IDLE: on trigger, snapshot all nine cells into a register, clear scan flags, go to SCAN.
  - SCAN: 8 cycles, one line per cycle. Line order: rows 012, 345, 678; columns 036, 147, 258; diagonals 048, 246. All evaluation uses the snapshot only.
    - If the line holds two O and one empty and no win is recorded yet, record the empty cell as win.
    - If the line holds two X and one empty and no block is recorded yet, record the empty cell as block.
  - PICK: 1 cycle. Choose win, else block, else 4 if empty, else the first empty of 0, 2, 6, 8, else the first empty of 1, 3, 5, 7. Register the result into `computer_position`.
  - ISSUE: `pc`=1.
    - When the live cell at `computer_position` reads 10: go to WAIT.
    - If HOLD_CYCLES cycles pass without that: set `error`, go to WAIT.
  - WAIT: `pc`=0. Return to IDLE once nx = no, or `who`≠00, or `enable`=0. Only then can the engine re-arm.
- Abort: in SCAN, PICK or ISSUE, if `enable`=0 or `who`≠00, go to IDLE. `pc` is 0 on the next cycle.
- `computer_position` holds its last value outside ISSUE.
- Reset mid-operation: IDLE next cycle, all outputs 0, snapshot discarded.

## Timing
- Trigger true in cycle t: SCAN covers t+1..t+8, PICK is t+9, and `pc` plus a valid `computer_position` appear from t+10.
- `pc` is high for at least 1 and at most HOLD_CYCLES cycles per move, with exactly one rising edge per turn.
- Ack observed in cycle a: `pc` is low in a+1.
- Board changes during SCAN or PICK do not alter the chosen cell. The move is re-validated only by the ack or timeout in ISSUE.
- Minimum time between two `pc` rising edges: 12 cycles.

## Structure
- Shared package `ttt_pkg` holds:
  - Cell codes EMPTY/PX/PO/BAD.
  - `who` codes.
  - The 8×3 line table as constant cell indices.
  - The corner and edge preference lists.
  - The FSM state enum.
- Sub-module `ttt_line_eval` (combinational):
  - Inputs: three 2-bit cells and their three indices.
  - Outputs: `o_two`, `x_two`, and the empty index.
  - Used once by SCAN, driven by a 3-bit line counter.
- Top level holds the FSM, snapshot register, counters, priority picker and hold timer.

## Test plan
- Empty board with enable=1 → no trigger; `pc` stays 0 and `busy`=0.
- Player takes 0 → `pc` rises 10 cycles later with `computer_position`=4. Model writes 10 to `pos5` after 2 cycles → `pc` falls the next cycle.
- X at 0, 1 and O at 4 → block chosen, position 2.
- X at 0, 1, 8 and O at 4, 5 → win (3) beats block (2); position 3.
- Model never acks → `pc` is high for exactly 5 cycles, then `error`=1 and the engine waits in WAIT.
- `who` goes to 01 during SCAN, or reset pulses during ISSUE → IDLE, `pc`=0 the next cycle, no further request.
